// File: rtl/klingon_glyph_if.sv
// Glyph-in / BCD-word-out handshake bundle for the Klingon glyph decoder.
// The decoder uses the slave modport; the glyph source and word consumer use the master modport.
interface klingon_glyph_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          in_glyph;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic [3:0]          out_count;
    logic                out_err;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  in_glyph, in_valid, in_last, out_ready,
        output in_ready, out_bcd, out_count, out_err, out_valid
    );

    modport master (
        output in_glyph, in_valid, in_last, out_ready,
        input  in_ready, out_bcd, out_count, out_err, out_valid
    );
endinterface

// File: rtl/klingon_glyph_decoder.sv
// Decodes 7-bit Klingon glyphs to digits and packs them, first digit most significant,
// into a BCD word handed off on a valid/ready output.
//
// state   | meaning
// COLLECT | accepting glyphs, shifting decoded nibbles into acc
// EMIT    | word held on the outputs until the consumer takes it
module klingon_glyph_decoder #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    klingon_glyph_if.slave   bus
);
    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] acc;
    logic [3:0]          cnt;
    logic                err;

    logic [3:0]          nibble;
    logic                illegal;
    logic [4*DIGITS+3:0] shifted;
    logic [3:0]          cnt_inc;

    always_comb begin
        nibble  = 4'hF;
        illegal = 1'b0;
        case (bus.in_glyph)
            7'b1111110: nibble = 4'd0;
            7'b1000000: nibble = 4'd1;
            7'b1000001: nibble = 4'd2;
            7'b1001001: nibble = 4'd3;
            7'b0100011: nibble = 4'd4;
            7'b0011101: nibble = 4'd5;
            7'b0100101: nibble = 4'd6;
            7'b0010011: nibble = 4'd7;
            7'b0110110: nibble = 4'd8;
            7'b0110111: nibble = 4'd9;
            default:    illegal = 1'b1;
        endcase
    end

    // Shift through a wider vector so DIGITS=1 needs no special case.
    assign shifted = {acc, nibble};
    assign cnt_inc = cnt + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
            acc   <= '0;
            cnt   <= 4'd0;
            err   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        acc <= shifted[4*DIGITS-1:0];
                        cnt <= cnt_inc;
                        err <= err | illegal;
                        if (bus.in_last || (cnt_inc == 4'(DIGITS)))
                            state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        acc   <= '0;
                        cnt   <= 4'd0;
                        err   <= 1'b0;
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_bcd   = acc;
    assign bus.out_count = cnt;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_klingon_glyph_decoder.sv
// Directed bench for klingon_glyph_decoder with DIGITS=4; inputs change and outputs
// are sampled on the falling edge.
module tb_klingon_glyph_decoder;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    klingon_glyph_if #(.DIGITS(4)) bus ();

    klingon_glyph_decoder #(.DIGITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one glyph at a falling edge; returns at the next falling edge with in_valid low.
    task automatic put(input logic [6:0] g, input logic last);
        bus.in_glyph = g;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_glyph  = 7'd0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_bcd !== 16'h0000 || bus.out_count !== 4'd0 ||
            bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: valid=%b bcd=%h count=%0d err=%b in_ready=%b, required 0 0000 0 0 1",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err, bus.in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        put(7'b1000000, 1'b0);
        put(7'b0110111, 1'b0);
        put(7'b0110110, 1'b0);
        put(7'b0100011, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h1984 || bus.out_count !== 4'd4 ||
            bus.out_err !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_word: valid=%b bcd=%h count=%0d err=%b in_ready=%b, required 1 1984 4 0 0",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err, bus.in_ready);
        end
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_word_release: valid=%b in_ready=%b, required 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_short_word();
        put(7'b0010011, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h0007 || bus.out_count !== 4'd1 ||
            bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL short_word: valid=%b bcd=%h count=%0d err=%b, required 1 0007 1 0",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err);
        end
        idle();
    endtask

    task automatic test_illegal();
        put(7'b1000001, 1'b0);
        put(7'b0000000, 1'b0);
        put(7'b0011101, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h02F5 || bus.out_count !== 4'd3 ||
            bus.out_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_word: valid=%b bcd=%h count=%0d err=%b, required 1 02f5 3 1",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err);
        end
        idle();
        put(7'b1111110, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h0000 || bus.out_count !== 4'd1 ||
            bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared: valid=%b bcd=%h count=%0d err=%b, required 1 0000 1 0",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err);
        end
        idle();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        put(7'b1001001, 1'b0);
        put(7'b0100101, 1'b1);
        bus.in_glyph = 7'b1111110;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_bcd !== 16'h0036 ||
                bus.out_count !== 4'd2 || bus.out_err !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: valid=%b in_ready=%b bcd=%h count=%0d err=%b, required 1 0 0036 2 0",
                         c, bus.out_valid, bus.in_ready, bus.out_bcd, bus.out_count, bus.out_err);
            end
            if (c < 2) idle();
        end
        bus.out_ready = 1'b1;
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 4'd0) begin
            failures++;
            $display("FAIL backpressure_handshake: valid=%b in_ready=%b count=%0d, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_count);
        end
        idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h0000 || bus.out_count !== 4'd1 ||
            bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_held_glyph: valid=%b bcd=%h count=%0d err=%b, required 1 0000 1 0",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err);
        end
        idle();
    endtask

    task automatic test_all_patterns();
        logic [6:0] legal_tab [10];
        logic [3:0] exp_nib;
        logic       exp_err;
        legal_tab = '{7'b1111110, 7'b1000000, 7'b1000001, 7'b1001001, 7'b0100011,
                      7'b0011101, 7'b0100101, 7'b0010011, 7'b0110110, 7'b0110111};
        for (int g = 0; g < 128; g++) begin
            exp_nib = 4'hF;
            exp_err = 1'b1;
            for (int k = 0; k < 10; k++) begin
                if (legal_tab[k] == 7'(g)) begin
                    exp_nib = 4'(k);
                    exp_err = 1'b0;
                end
            end
            put(7'(g), 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bcd !== {12'h000, exp_nib} ||
                bus.out_count !== 4'd1 || bus.out_err !== exp_err) begin
                failures++;
                $display("FAIL pattern_%b: valid=%b bcd=%h count=%0d err=%b, required 1 %h 1 %b",
                         7'(g), bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err,
                         {12'h000, exp_nib}, exp_err);
            end
            idle();
        end
    endtask

    task automatic test_last_at_full();
        put(7'b0100011, 1'b0);
        put(7'b0010011, 1'b0);
        put(7'b1000000, 1'b0);
        put(7'b0110111, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h4719 || bus.out_count !== 4'd4) begin
            failures++;
            $display("FAIL last_at_full: valid=%b bcd=%h count=%0d, required 1 4719 4",
                     bus.out_valid, bus.out_bcd, bus.out_count);
        end
        idle();
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_count !== 4'd0) begin
            failures++;
            $display("FAIL last_at_full_single: valid=%b count=%0d, required 0 0",
                     bus.out_valid, bus.out_count);
        end
    endtask

    task automatic test_back_to_back();
        put(7'b0110110, 1'b0);
        put(7'b0100101, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h0086 || bus.out_count !== 4'd2) begin
            failures++;
            $display("FAIL back_to_back_a: valid=%b bcd=%h count=%0d, required 1 0086 2",
                     bus.out_valid, bus.out_bcd, bus.out_count);
        end
        idle();
        put(7'b0011101, 1'b0);
        put(7'b0100011, 1'b0);
        put(7'b1001001, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h0543 || bus.out_count !== 4'd3 ||
            bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_b: valid=%b bcd=%h count=%0d err=%b, required 1 0543 3 0",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err);
        end
        idle();
    endtask

    task automatic test_reset_mid_word();
        put(7'b0110110, 1'b0);
        put(7'b0110111, 1'b0);
        checks++;
        if (bus.out_count !== 4'd2 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_word_partial: count=%0d valid=%b, required 2 0",
                     bus.out_count, bus.out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_bcd !== 16'h0000 || bus.out_count !== 4'd0 ||
            bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: valid=%b bcd=%h count=%0d err=%b in_ready=%b, required 0 0000 0 0 1",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err, bus.in_ready);
        end
        #1 reset_n = 1'b1;
        @(negedge clk);
        put(7'b1000000, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h0001 || bus.out_count !== 4'd1 ||
            bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_word: valid=%b bcd=%h count=%0d err=%b, required 1 0001 1 0",
                     bus.out_valid, bus.out_bcd, bus.out_count, bus.out_err);
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_word();
        test_short_word();
        test_illegal();
        test_backpressure();
        test_all_patterns();
        test_last_at_full();
        test_back_to_back();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
